// File: rtl/sap_ram_arbiter.sv
// rtl/sap_ram_arbiter.sv - shares the SAP program/data RAM between the CPU and an external loader
module sap_ram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [5:0]        cpu_ring,
  input  logic              cpu_hlt,
  input  logic              cpu_ce,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              ld_req,
  input  logic              ld_stb,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_WAIT  = 3'd1,
    S_GRANT = 3'd2,
    S_ACC   = 3'd3,
    S_ACK   = 3'd4
  } state_e;

  localparam logic [5:0] RING_T6 = 6'b100000;

  state_e state_q, state_d;

  // Loader request captured on the strobe; replayed to the RAM during ACC.
  logic              cap_we_q;
  logic [ADDR_W-1:0] cap_addr_q;
  logic [DATA_W-1:0] cap_wdata_q;

  logic              gnt_q,   gnt_d;
  logic              ack_q,   ack_d;
  logic [DATA_W-1:0] rdata_q;

  // The loader may only take the RAM between instructions or when the CPU is parked.
  logic boundary;
  assign boundary = (cpu_ring == RING_T6) | cpu_hlt;

  // State register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a strobe in GRANT wins over ld_req falling in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN: begin
        if (ld_req) begin
          state_d = boundary ? S_GRANT : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!ld_req) begin
          state_d = S_RUN;
        end else if (boundary) begin
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (ld_stb) begin
          state_d = S_ACC;
        end else if (!ld_req) begin
          state_d = S_RUN;
        end
      end
      S_ACC:   state_d = S_ACK;
      S_ACK:   state_d = S_GRANT;
      default: state_d = S_RUN;
    endcase
  end

  // Grant/hold and ack are registered from the next state so they rise with the state change.
  always_comb begin
    gnt_d = (state_d == S_GRANT) || (state_d == S_ACC) || (state_d == S_ACK);
    ack_d = (state_d == S_ACK);
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      gnt_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      gnt_q <= gnt_d;
      ack_q <= ack_d;
    end
  end

  // Capture the loader command on an accepted strobe.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cap_we_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
    end else if ((state_q == S_GRANT) && ld_stb) begin
      cap_we_q    <= ld_we;
      cap_addr_q  <= ld_addr;
      cap_wdata_q <= ld_wdata;
    end
  end

  // Read data is taken on the ACC->ACK edge and held until the next read.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rdata_q <= '0;
    end else if ((state_q == S_ACC) && !cap_we_q) begin
      rdata_q <= ram_rdata;
    end
  end

  // RAM mux: CPU drives the RAM in RUN/WAIT, the captured loader command otherwise.
  always_comb begin
    ram_addr  = cpu_addr;
    ram_ce    = cpu_ce;
    ram_we    = 1'b0;
    ram_wdata = cap_wdata_q;
    unique case (state_q)
      S_RUN, S_WAIT: begin
        ram_addr = cpu_addr;
        ram_ce   = cpu_ce;
      end
      S_GRANT, S_ACK: begin
        ram_addr = cap_addr_q;
        ram_ce   = 1'b0;
      end
      S_ACC: begin
        ram_addr = cap_addr_q;
        ram_ce   = 1'b1;
        ram_we   = cap_we_q;
      end
      default: begin
        ram_addr = cpu_addr;
        ram_ce   = cpu_ce;
      end
    endcase
  end

  assign ld_gnt   = gnt_q;
  assign cpu_hold = gnt_q;
  assign ld_ack   = ack_q;
  assign ld_rdata = rdata_q;

endmodule

// File: tb/tb_sap_ram_arbiter.sv
// tb/tb_sap_ram_arbiter.sv - scoreboard bench for sap_ram_arbiter
module tb_sap_ram_arbiter;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [5:0] cpu_ring;
  logic       cpu_hlt, cpu_ce;
  logic [3:0] cpu_addr;
  logic       ld_req, ld_stb, ld_we;
  logic [3:0] ld_addr;
  logic [7:0] ld_wdata;
  logic       ld_gnt, ld_ack, cpu_hold;
  logic [7:0] ld_rdata;
  logic [3:0] ram_addr;
  logic       ram_ce, ram_we;
  logic [7:0] ram_wdata, ram_rdata;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T6 = 6'b100000;

  sap_ram_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .clr_n(clr_n), .cpu_ring(cpu_ring), .cpu_hlt(cpu_hlt), .cpu_ce(cpu_ce),
    .cpu_addr(cpu_addr), .ld_req(ld_req), .ld_stb(ld_stb), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_ack(ld_ack),
    .ld_rdata(ld_rdata), .cpu_hold(cpu_hold), .ram_addr(ram_addr), .ram_ce(ram_ce),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Control-unit ring counter model: advances on negedge unless held.
  logic       ring_en, ring_load;
  logic [5:0] ring_val;
  always @(negedge clk or negedge clr_n) begin
    if (!clr_n) cpu_ring <= T1;
    else if (ring_load) cpu_ring <= ring_val;
    else if (ring_en && !cpu_hold) cpu_ring <= {cpu_ring[4:0], cpu_ring[5]};
  end

  // 16x8 RAM model, asynchronous read, preloaded with 0x10+i.
  logic [7:0] mem [16];
  logic       mem_preload;
  always @(posedge clk) begin
    if (mem_preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end
  assign ram_rdata = mem[ram_addr];

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  int         n_checks = 0;
  int         n_fail   = 0;
  int         we_count = 0;
  logic [7:0] last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int max_cyc);
    for (int i = 0; i < max_cyc && !ld_gnt; i++) step();
    chk("grant_within_bound", ld_gnt, 1);
  endtask

  // Issue one loader access from GRANT and return once back in GRANT.
  task automatic access(input logic we, input logic [3:0] a, input logic [7:0] d,
                        input logic [7:0] rd_exp);
    exp_t e;
    int   wc0;
    e.cyc  = cycle_cnt + 2;
    e.data = we ? last_rd : rd_exp;
    if (!we) last_rd = rd_exp;
    exp_q.push_back(e);
    wc0      = we_count;
    ld_stb   = 1'b1;
    ld_we    = we;
    ld_addr  = a;
    ld_wdata = d;
    step();
    ld_stb = 1'b0;
    chk("acc_ram_we", ram_we, we);
    chk("acc_ram_addr", ram_addr, a);
    chk("acc_ram_ce", ram_ce, 1);
    step();
    step();
    chk("we_pulse_count", we_count - wc0, we);
  endtask

  // Monitor: counts write strobes and checks each ack against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (ram_we) we_count++;
      if (ld_ack) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack with rdata %0h, expected no ack (t=%0t)", ld_rdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("ack_cycle", cycle_cnt, e.cyc);
          chk("ack_rdata", ld_rdata, e.data);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n = 1'b0; ld_req = 1'b0; ld_stb = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    cpu_hlt = 1'b0; cpu_ce = 1'b0; cpu_addr = '0;
    ring_en = 1'b0; ring_load = 1'b0; ring_val = T1; mem_preload = 1'b1; last_rd = 8'h00;

    // Reset with random inputs.
    for (int i = 0; i < 4; i++) begin
      step();
      cpu_addr = 4'($urandom); cpu_ce = 1'($urandom); cpu_hlt = 1'($urandom);
      ld_req = 1'($urandom); ld_stb = 1'($urandom); ld_we = 1'($urandom);
      ld_addr = 4'($urandom); ld_wdata = 8'($urandom);
      #1;
      chk("rst_gnt", ld_gnt, 0);
      chk("rst_hold", cpu_hold, 0);
      chk("rst_ack", ld_ack, 0);
      chk("rst_rdata", ld_rdata, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, cpu_addr);
      chk("rst_ram_ce", ram_ce, cpu_ce);
    end
    step();
    ld_req = 1'b0; ld_stb = 1'b0; cpu_hlt = 1'b0; cpu_ce = 1'b1; cpu_addr = 4'h9;
    mem_preload = 1'b0; clr_n = 1'b1; ring_en = 1'b1;

    // Boundary wait: request at T2, grant only once T6 is sampled.
    for (int i = 0; i < 8 && cpu_ring != T2; i++) step();
    chk("ring_at_t2", cpu_ring, T2);
    ld_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wait_no_gnt", ld_gnt, 0);
      chk("wait_ram_addr_cpu", ram_addr, 4'h9);
    end
    chk("wait_ring_t6", cpu_ring, T6);
    step();
    chk("bnd_gnt", ld_gnt, 1);
    chk("bnd_hold", cpu_hold, 1);
    chk("gnt_ram_ce", ram_ce, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_ring_t6", cpu_ring, T6);
    end

    // Write / read back and further patterns.
    access(1'b1, 4'h3, 8'hA5, 8'h00);
    access(1'b0, 4'h3, 8'h00, 8'hA5);
    access(1'b0, 4'h7, 8'h00, 8'h17);
    access(1'b1, 4'h0, 8'h5A, 8'h00);
    chk("rdata_held_after_write", ld_rdata, 8'h17);
    access(1'b0, 4'h0, 8'h00, 8'h5A);

    // Release and resume at T1.
    ld_req = 1'b0;
    step();
    chk("rel_gnt", ld_gnt, 0);
    chk("rel_hold", cpu_hold, 0);
    chk("rel_ring_t1", cpu_ring, T1);

    // Stray strobe outside GRANT is ignored.
    begin
      int wc0;
      wc0 = we_count;
      ld_stb = 1'b1; ld_we = 1'b1; ld_addr = 4'h3; ld_wdata = 8'hFF;
      step();
      ld_stb = 1'b0;
      step();
      step();
      chk("stray_no_we", we_count - wc0, 0);
      chk("stray_mem3", mem[3], 8'hA5);
    end

    // Halted CPU: grant at T4 without waiting for T6.
    ring_load = 1'b1; ring_val = T4;
    step();
    ring_load = 1'b0; ring_en = 1'b0; cpu_hlt = 1'b1; ld_req = 1'b1;
    step();
    chk("hlt_gnt", ld_gnt, 1);
    chk("hlt_ring_t4", cpu_ring, T4);
    access(1'b0, 4'h3, 8'h00, 8'hA5);
    ld_req = 1'b0; cpu_hlt = 1'b0;
    step();
    chk("hlt_rel_gnt", ld_gnt, 0);

    // Strobe together with ld_req falling: access completes, then release.
    ring_load = 1'b1; ring_val = T1;
    step();
    ring_load = 1'b0; ring_en = 1'b1; ld_req = 1'b1;
    wait_gnt(12);
    chk("sim_ring_t6", cpu_ring, T6);
    begin
      exp_t e;
      e.cyc = cycle_cnt + 2;
      e.data = last_rd;
      exp_q.push_back(e);
    end
    ld_stb = 1'b1; ld_we = 1'b1; ld_addr = 4'hF; ld_wdata = 8'h3C; ld_req = 1'b0;
    step();
    ld_stb = 1'b0;
    chk("sim_acc_we", ram_we, 1);
    chk("sim_acc_gnt", ld_gnt, 1);
    step();
    chk("sim_ack_gnt", ld_gnt, 1);
    step();
    chk("sim_grant_hold", cpu_hold, 1);
    chk("sim_grant_ring", cpu_ring, T6);
    step();
    chk("sim_rel_gnt", ld_gnt, 0);
    chk("sim_resume_t1", cpu_ring, T1);
    chk("sim_mem15", mem[15], 8'h3C);

    // Reset during ACC of a write.
    ring_en = 1'b0; cpu_hlt = 1'b1; ld_req = 1'b1;
    step();
    chk("mid_gnt", ld_gnt, 1);
    ld_stb = 1'b1; ld_we = 1'b1; ld_addr = 4'h5; ld_wdata = 8'h77;
    step();
    ld_stb = 1'b0;
    chk("mid_we_high", ram_we, 1);
    clr_n = 1'b0;
    #1;
    chk("mid_we_drop", ram_we, 0);
    chk("mid_gnt_drop", ld_gnt, 0);
    chk("mid_hold_drop", cpu_hold, 0);
    chk("mid_ram_addr_cpu", ram_addr, cpu_addr);
    last_rd = 8'h00;
    ld_req = 1'b0; cpu_hlt = 1'b0;
    step();
    chk("mid_rdata_rst", ld_rdata, 0);
    chk("mid_no_write", mem[5], 8'h15);
    clr_n = 1'b1;
    repeat (3) step();
    chk("mid_no_ack", ld_ack, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
